// File: rtl/fp32_pkg.sv
// FP32 field constants and the 2-bit result class encoding shared by the
// multiplier result stage, its classifier and its bus interface.
package fp32_pkg;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fp_class_e;

    localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
    localparam logic [7:0]  EXP_ZERO     = 8'h00;
    localparam logic [31:0] QNAN         = 32'h7FC00000;

endpackage

// File: rtl/fp32_mul_result_stage_if.sv
// Producer/consumer handshake bundle of the result stage: the multiplier push
// side and the consumer pop side. The stage uses the slave modport.
interface fp32_mul_result_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [1:0]  out_class;

    modport master (
        output in_valid, in_result, out_ready,
        input  in_ready, out_valid, out_result, out_class
    );

    modport slave (
        input  in_valid, in_result, out_ready,
        output in_ready, out_valid, out_result, out_class
    );

endinterface

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier: NaN, infinity, zero (denormals fold into
// zero) or normal.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0] value_i,
    output fp_class_e   class_o
);

    logic [7:0]  exp_w;
    logic [22:0] mant_w;
    logic        unused_sign;

    assign exp_w       = value_i[30:23];
    assign mant_w      = value_i[22:0];
    assign unused_sign = value_i[31];

    always_comb begin
        class_o = CLS_NORMAL;
        if (exp_w == EXP_ALL_ONES) begin
            class_o = (mant_w != '0) ? CLS_NAN : CLS_INF;
        end else if (exp_w == EXP_ZERO) begin
            class_o = CLS_ZERO;
        end
    end

endmodule

// File: rtl/fp32_mul_result_stage.sv
// Output buffer for fp32 multiplier results: DEPTH-entry FIFO tagging each
// entry with its class, plus sticky class flags. Define
// FP32_RESULT_EVENT_CNT_EN to add saturating per-class push counters.
module fp32_mul_result_stage
    import fp32_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fp32_mul_result_stage_if.slave  bus,
    input  logic                    flag_clr,
    output logic [2:0]              sticky_flags
`ifdef FP32_RESULT_EVENT_CNT_EN
    ,
    output logic [15:0]             cnt_nan,
    output logic [15:0]             cnt_inf,
    output logic [15:0]             cnt_zero
`endif
);

    localparam int            PW   = $clog2(DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fp_class_e              in_class;
    logic                   not_full;
    logic                   not_empty;
    logic                   push;
    logic                   pop;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DEPTH-1:0][31:0] data_q;
    logic [DEPTH-1:0][1:0]  class_q;
    logic [2:0]             flags_q, flags_d;
    logic [2:0]             push_bits;

    fp32_classify u_classify (
        .value_i (bus.in_result),
        .class_o (in_class)
    );

    // Ready depends only on occupancy, so a full buffer never passes through.
    assign not_full  = (count_q != FULL);
    assign not_empty = (count_q != '0);
    assign push      = bus.in_valid & not_full;
    assign pop       = not_empty & bus.out_ready;

    assign bus.in_ready   = not_full;
    assign bus.out_valid  = not_empty;
    assign bus.out_result = not_empty ? data_q[rd_ptr_q]  : 32'h0;
    assign bus.out_class  = not_empty ? class_q[rd_ptr_q] : 2'b00;
    assign sticky_flags   = flags_q;

    // Bit order {nan, inf, zero}; clear is applied first so a coinciding push wins.
    always_comb begin
        push_bits = {push && (in_class == CLS_NAN),
                     push && (in_class == CLS_INF),
                     push && (in_class == CLS_ZERO)};
        flags_d   = (flag_clr ? 3'b000 : flags_q) | push_bits;
        count_d   = count_q + CW'(push) - CW'(pop);
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            flags_q  <= '0;
            data_q   <= '0;
            class_q  <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
            if (push) begin
                data_q[wr_ptr_q]  <= bus.in_result;
                class_q[wr_ptr_q] <= in_class;
            end
        end
    end

`ifdef FP32_RESULT_EVENT_CNT_EN
    logic [2:0][15:0] cnt_q, cnt_d;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = flag_clr ? 16'h0 : cnt_q[i];
            if (push_bits[i] && (cnt_d[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_d[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_nan  = cnt_q[2];
    assign cnt_inf  = cnt_q[1];
    assign cnt_zero = cnt_q[0];
`endif

endmodule

// File: tb/tb_fp32_mul_result_stage.sv
// Randomized and directed bench for fp32_mul_result_stage against a queue-based
// reference model of the buffer, class rules, sticky flags and counters.
module tb_fp32_mul_result_stage;
    import fp32_pkg::*;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flag_clr = 1'b0;
    logic [2:0] sticky_flags;
`ifdef FP32_RESULT_EVENT_CNT_EN
    logic [15:0] cnt_nan, cnt_inf, cnt_zero;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mq[$];
    logic [2:0]  m_flags = 3'b000;
    int          m_cnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    fp32_mul_result_stage_if bus ();

    fp32_mul_result_stage #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .flag_clr     (flag_clr),
        .sticky_flags (sticky_flags)
`ifdef FP32_RESULT_EVENT_CNT_EN
        ,
        .cnt_nan      (cnt_nan),
        .cnt_inf      (cnt_inf),
        .cnt_zero     (cnt_zero)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // IEEE-754 class by field inspection: 3 NaN, 2 inf, 1 zero, 0 normal.
    function automatic int ref_class(input logic [31:0] v);
        int e = int'(v[30:23]);
        int m = int'(v[22:0]);
        if (e == 255) return (m != 0) ? 3 : 2;
        if (e == 0) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] v = $urandom;
        case ($urandom_range(0, 5))
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = '0; end
            2: begin v[30:23] = 8'hFF; if (v[22:0] == '0) v[0] = 1'b1; end
            3: v = QNAN;
            default: ;
        endcase
        return v;
    endfunction

    task automatic check_all();
        int sz = mq.size();
        chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
        chk("in_ready", 32'(bus.in_ready), 32'(sz < DEPTH));
        chk("out_result", bus.out_result, (sz != 0) ? mq[0] : 32'h0);
        chk("out_class", 32'(bus.out_class), (sz != 0) ? 32'(ref_class(mq[0])) : 32'h0);
        chk("sticky", 32'(sticky_flags), 32'(m_flags));
`ifdef FP32_RESULT_EVENT_CNT_EN
        chk("cnt_nan", 32'(cnt_nan), 32'(m_cnt[2]));
        chk("cnt_inf", 32'(cnt_inf), 32'(m_cnt[1]));
        chk("cnt_zero", 32'(cnt_zero), 32'(m_cnt[0]));
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic ordy, input logic clr);
        bus.in_valid  = v;
        bus.in_result = r;
        bus.out_ready = ordy;
        flag_clr      = clr;
    endtask

    // One clock: model the edge from the inputs held across it, then check at negedge.
    task automatic step();
        bit push, pop;
        int c, bitn;
        @(posedge clk);
        push = bus.in_valid && (mq.size() < DEPTH);
        pop  = bus.out_ready && (mq.size() > 0);
        c    = ref_class(bus.in_result);
        bitn = (c == 3) ? 2 : (c == 2) ? 1 : (c == 1) ? 0 : -1;
        if (flag_clr) begin
            m_flags = 3'b000;
            m_cnt   = '{0, 0, 0};
        end
        if (push && bitn >= 0) begin
            m_flags[bitn] = 1'b1;
            if (m_cnt[bitn] < 65535) m_cnt[bitn]++;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(bus.in_result);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Single normal result, one-cycle latency.
        drive(1'b1, 32'h40400000, 1'b1, 1'b0);
        step();
        chk("single_res", bus.out_result, 32'h40400000);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();

        // Fill to full with consumer stalled, then drain.
        drive(1'b1, 32'h3F800000, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h7F800000, 1'b0, 1'b0);
        step();
        chk("full_ready", 32'(bus.in_ready), 32'h0);
        drive(1'b1, 32'h40000000, 1'b0, 1'b0);
        step();
        step();
        chk("held_head", bus.out_result, 32'h3F800000);
        drive(1'b1, 32'h40000000, 1'b1, 1'b0);
        step();
        chk("drain_head", bus.out_result, 32'h7F800000);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) step();

        // NaN then zero classes and sticky flags.
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'hFFC00000, 1'b1, 1'b0);
        step();
        chk("nan_class", 32'(bus.out_class), 32'h3);
        drive(1'b1, 32'h80000000, 1'b1, 1'b0);
        step();
        chk("zero_class", 32'(bus.out_class), 32'h1);
        chk("sticky_101", 32'(sticky_flags), 32'h5);

        // Push coinciding with clear leaves only that push's flag.
        drive(1'b1, 32'h7F800000, 1'b1, 1'b0);
        step();
        chk("sticky_111", 32'(sticky_flags), 32'h7);
        drive(1'b1, 32'h7F800000, 1'b1, 1'b1);
        step();
        chk("sticky_clr_set", 32'(sticky_flags), 32'h2);

        // Reset with two entries buffered.
        drive(1'b1, 32'h3F800000, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h40400000, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        mq.delete();
        m_flags = 3'b000;
        m_cnt   = '{0, 0, 0};
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), rnd_val(), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0));
            step();
        end

`ifdef FP32_RESULT_EVENT_CNT_EN
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        drive(1'b1, QNAN, 1'b1, 1'b0);
        repeat (65537) step();
        chk("cnt_nan_sat", 32'(cnt_nan), 32'hFFFF);
        chk("cnt_inf_0", 32'(cnt_inf), 32'h0);
        chk("cnt_zero_0", 32'(cnt_zero), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        step();
        chk("cnt_nan_clr", 32'(cnt_nan), 32'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp32_mul_result_stage.md
FP32_MUL_RESULT_STAGE -- requirements
Module: fp32_mul_result_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, output buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  multiplier result valid.
REQ-005 SHALL have port in_ready  output  1  stage can accept a result.
REQ-006 SHALL have port in_result  input  32  IEEE-754 single-precision product from fp32_multiplier.
REQ-007 SHALL have port out_valid  output  1  head entry valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-009 SHALL have port out_result  output  32  head entry result, unchanged bit pattern.
REQ-010 SHALL have port out_class  output  2  head entry class: 00 normal, 01 zero, 10 infinity, 11 NaN.
REQ-011 SHALL have port sticky_flags  output  3  {nan, inf, zero} seen since last clear.
REQ-012 SHALL have port flag_clr  input  1  synchronous clear of sticky flags (and counters when compiled in).

Function
REQ-013 Classification SHALL be: exp==FF and mant!=0 -> NaN; exp==FF and mant==0 -> inf; exp==00 -> zero (regardless of mantissa); else normal.
REQ-014 Push SHALL occur on a rising edge where in_valid and in_ready are both high; pop SHALL occur where out_valid and out_ready are both high.
REQ-015 in_ready SHALL equal "buffer not full", registered-independent of out_ready (no same-cycle pass-through when full).
REQ-016 Latency SHALL be one cycle: a result pushed at edge t is visible with out_valid high after edge t.
REQ-017 Entries SHALL leave in push order; out_class SHALL be stored with each entry at push time.
REQ-018 When empty, out_valid SHALL be 0 and out_result/out_class SHALL be driven 0.
REQ-019 Simultaneous push and pop when neither full nor empty SHALL keep occupancy unchanged; when empty, only push is possible; when full, only pop.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-021 out_result and out_class SHALL be held stable while out_valid is high and out_ready is low.
REQ-022 A sticky flag bit SHALL set on push of a result of its class; flag_clr SHALL clear all bits; a push coinciding with flag_clr SHALL leave only that push's bit set (set wins).

Reset
REQ-023 rst_n low SHALL asynchronously force: occupancy 0, pointers 0, out_valid 0, out_result 0, out_class 00, sticky_flags 000, in_ready 1 after release, counters 0.
REQ-024 Reset asserted mid-transfer SHALL discard all buffered entries; no entry SHALL be emitted after release without a new push.

Configuration
REQ-025 Macro FP32_RESULT_EVENT_CNT_EN, when defined, SHALL add outputs cnt_nan, cnt_inf, cnt_zero (each 16 bits), incremented on push of a result of that class, saturating at 0xFFFF, cleared by flag_clr (push coinciding with clear yields 1).
REQ-026 Without FP32_RESULT_EVENT_CNT_EN those ports and registers SHALL be absent; all other behaviour identical.

Structure
REQ-027 Package fp32_pkg SHALL hold the 2-bit class encoding constants, EXP_ALL_ONES (8'hFF), EXP_ZERO (8'h00), and the canonical QNAN pattern 32'h7FC00000.
REQ-028 Classification SHALL be a combinational sub-module fp32_classify (in: 32-bit value; out: 2-bit class), instantiated once on in_result.

Verification
REQ-029 Reset then push 32'h40400000 (3.0) with out_ready=1 -> out_valid next cycle, out_result 40400000, out_class 00, sticky 000.
REQ-030 out_ready=0, push DEPTH=2 results 3F800000, 7F800000 -> in_ready 0 after second push; third in_valid held; raise out_ready -> outputs 3F800000 then 7F800000, in_ready returns 1.
REQ-031 Push FFC00000 and 80000000 -> out_class 11 then 01; sticky_flags 101.
REQ-032 Push 7F800000 in the same cycle as flag_clr=1 with sticky 111 -> sticky_flags 010 next cycle.
REQ-033 Assert rst_n low with 2 entries buffered -> out_valid 0 immediately, no output after release until a new push.
REQ-034 With FP32_RESULT_EVENT_CNT_EN, push 65537 NaN results -> cnt_nan 0xFFFF, cnt_inf 0, cnt_zero 0; flag_clr -> all 0.
